// File: rtl/i2c_cfg_arbiter.sv
// Round-robin arbiter and sequencer sharing one I2C engine among N_REQ requesters.
// Grants one transaction at a time, guards it with a watchdog, and supports a lock for atomic sequences.
module i2c_cfg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 200_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_lock,
  input  logic [32*N_REQ-1:0]  req_cmd,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_done,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [15:0]          rsp_rdata,
  output logic                 eng_start,
  output logic [31:0]          eng_cmd,
  output logic                 eng_abort,
  input  logic                 eng_done,
  input  logic                 eng_nack,
  input  logic [15:0]          eng_rdata,
  output logic                 busy
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYC - 1);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             lock_vld_q, lock_vld_d;
  logic [IW-1:0]    lock_own_q, lock_own_d;
  logic [31:0]      eng_cmd_q, eng_cmd_d;
  logic [23:0]      wdog_q, wdog_d;
  logic [15:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  logic             lock_hold;
  logic [N_REQ-1:0] cand;
  logic             pick_vld;
  logic [IW-1:0]    pick_idx;

  // The lock survives in IDLE only while the owner still shows req or req_lock.
  assign lock_hold = lock_vld_q && (req[lock_own_q] || req_lock[lock_own_q]);
  assign cand      = lock_hold ? (req & (ONE << lock_own_q)) : req;

  // Iterate from the farthest candidate down so the nearest one after ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (cand[IW'((int'(ptr_q) + k) % N_REQ)]) begin
        pick_vld = 1'b1;
        pick_idx = IW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    gnt_d         = gnt_q;
    lock_vld_d    = lock_vld_q;
    lock_own_d    = lock_own_q;
    eng_cmd_d     = eng_cmd_q;
    wdog_d        = wdog_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (lock_vld_q && !lock_hold) lock_vld_d = 1'b0;
        if (pick_vld) begin
          sel_d     = pick_idx;
          gnt_d     = ONE << pick_idx;
          eng_cmd_d = req_cmd[32*pick_idx +: 32];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          rsp_rdata_d   = eng_rdata;
          rsp_err_d     = eng_nack;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (wdog_q == WD_LAST) begin
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          wdog_d = wdog_q + 24'd1;
        end
      end
      default: begin
        ptr_d      = sel_q;
        lock_vld_d = req_lock[sel_q];
        lock_own_d = sel_q;
        gnt_d      = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= IW'(N_REQ - 1);
      sel_q         <= '0;
      gnt_q         <= '0;
      lock_vld_q    <= 1'b0;
      lock_own_q    <= '0;
      eng_cmd_q     <= '0;
      wdog_q        <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      gnt_q         <= gnt_d;
      lock_vld_q    <= lock_vld_d;
      lock_own_q    <= lock_own_d;
      eng_cmd_q     <= eng_cmd_d;
      wdog_q        <= wdog_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // A done in the expiry cycle wins, so abort is suppressed by eng_done.
  assign eng_abort   = (state_q == S_WAIT) && !eng_done && (wdog_q == WD_LAST);
  assign eng_start   = (state_q == S_ISSUE);
  assign rsp_done    = (state_q == S_RESP) ? gnt_q : '0;
  assign gnt         = gnt_q;
  assign eng_cmd     = eng_cmd_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Bench for i2c_cfg_arbiter: vector table plus lock, timeout and reset sequences, checked by a scoreboard.
module tb_i2c_cfg_arbiter;
  localparam int N = 4;
  localparam int T = 100;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req, req_lock, gnt, rsp_done;
  logic [32*N-1:0] req_cmd;
  logic          rsp_err, rsp_timeout, eng_start, eng_abort, busy;
  logic          eng_done, eng_nack;
  logic [15:0]   rsp_rdata, eng_rdata;
  logic [31:0]   eng_cmd;

  i2c_cfg_arbiter #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_cmd(req_cmd),
    .gnt(gnt), .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .rsp_rdata(rsp_rdata), .eng_start(eng_start), .eng_cmd(eng_cmd),
    .eng_abort(eng_abort), .eng_done(eng_done), .eng_nack(eng_nack),
    .eng_rdata(eng_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat=0 means the engine never finishes (watchdog case).
  typedef struct {
    logic [3:0]  req;
    int          lat;
    bit          nack;
    logic [15:0] rin;
    int          idx;
    bit          err;
    bit          to;
    logic [15:0] rdata;
    int          dly;
  } vec_t;

  vec_t        tab[8];
  vec_t        sb[$];
  logic [31:0] cmd_tab[4];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, drive_cyc = 0, start_cyc = 0;
  int done_cnt = 0, abort_cnt = 0, start_cnt = 0, n_push = 0;
  int eng_cnt = 0;
  bit front_started = 0;
  bit p_nack = 0;
  logic [15:0] p_rdata = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input vec_t v);
    sb.push_back(v);
    n_push++;
  endtask

  task automatic step();
    vec_t e;
    @(negedge clk);
    eng_done = 1'b0;
    eng_nack = 1'b0;
    if (rst) eng_cnt = 0;
    else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done  = 1'b1;
          eng_nack  = p_nack;
          eng_rdata = p_rdata;
        end
      end
      if (eng_start && sb.size() > 0) begin
        eng_cnt = sb[0].lat;
        p_nack  = sb[0].nack;
        p_rdata = sb[0].rin;
      end
    end
    #1;
    cyc++;
    if (eng_start) begin
      start_cnt++;
      if (sb.size() == 0) chk("unexpected_start", 32'(eng_start), 32'd0);
      else begin
        chk("start_once", 32'(front_started), 32'd0);
        chk("gnt_at_start", 32'(gnt), 32'(4'b0001 << sb[0].idx));
        chk("eng_cmd", eng_cmd, cmd_tab[sb[0].idx]);
        chk("start_delay", 32'(cyc - drive_cyc), 32'(sb[0].dly));
        front_started = 1'b1;
        start_cyc = cyc;
      end
    end
    if (eng_abort) begin
      abort_cnt++;
      chk("abort_delay", 32'(cyc - start_cyc), 32'(T));
      if (sb.size() > 0) chk("abort_expected", 32'(sb[0].lat == 0), 32'd1);
    end
    if (rsp_done != '0) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 32'(rsp_done), 32'd0);
      else begin
        e = sb.pop_front();
        front_started = 1'b0;
        chk("rsp_done_vec", 32'(rsp_done), 32'(4'b0001 << e.idx));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("done_delay", 32'(cyc - start_cyc), 32'((e.lat != 0) ? e.lat + 1 : T + 1));
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    if (done_cnt == d0) chk("done_wait_expired", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_rsp_done"}, 32'(rsp_done), 32'd0);
    chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    chk({tag, "_eng_abort"}, 32'(eng_abort), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_eng_cmd"}, eng_cmd, 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
  endtask

  initial begin
    // req, lat, nack, engine rdata, expected idx, err, timeout, rdata, start delay
    tab[0] = '{4'b0010, 50, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 16'h0000, 1};
    tab[1] = '{4'b1000, 12, 1'b0, 16'h1324, 3, 1'b0, 1'b0, 16'h1324, 2};
    tab[2] = '{4'b1000,  8, 1'b1, 16'h1324, 3, 1'b1, 1'b0, 16'h1324, 2};
    tab[3] = '{4'b1111, 10, 1'b0, 16'h1000, 0, 1'b0, 1'b0, 16'h1000, 2};
    tab[4] = '{4'b1111, 10, 1'b0, 16'h1001, 1, 1'b0, 1'b0, 16'h1001, 2};
    tab[5] = '{4'b1111, 10, 1'b0, 16'h1002, 2, 1'b0, 1'b0, 16'h1002, 2};
    tab[6] = '{4'b1111, 10, 1'b0, 16'h1003, 3, 1'b0, 1'b0, 16'h1003, 2};
    tab[7] = '{4'b1111, 10, 1'b0, 16'h1004, 0, 1'b0, 1'b0, 16'h1004, 2};
    cmd_tab[0] = 32'h2001_AAAA;
    cmd_tab[1] = 32'h900D_0300;
    cmd_tab[2] = 32'h3022_5555;
    cmd_tab[3] = 32'h9100_0000;
    req_cmd   = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};
    rst = 1'b1; req = '0; req_lock = '0;
    eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 16'h0;

    repeat (3) step();
    chk_quiet("reset");
    rst = 1'b0;
    step();

    // Single request, read/NACK pair, then a full round-robin lap.
    for (int i = 0; i < 8; i++) begin
      push(tab[i]);
      req = tab[i].req;
      drive_cyc = cyc;
      wait_done(300);
    end
    req = '0;
    step();

    // Watchdog expiry on requester 1, then arbitration moves on to requester 0.
    push('{4'b0011, 0, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 16'h1004, 1});
    req = 4'b0011;
    drive_cyc = cyc;
    wait_done(300);
    chk("abort_count", 32'(abort_cnt), 32'd1);
    push('{4'b0011, 5, 1'b0, 16'h2222, 0, 1'b0, 1'b0, 16'h2222, 2});
    drive_cyc = cyc;
    wait_done(300);

    // Requester 2 locks for three transactions while requester 0 keeps asking.
    req = 4'b0101;
    req_lock = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      push('{4'b0101, 6, 1'b0, 16'(16'h3000 + i), 2, 1'b0, 1'b0, 16'(16'h3000 + i), 2});
      drive_cyc = cyc;
      wait_done(300);
    end
    req = 4'b0001;
    req_lock = 4'b0000;
    push('{4'b0001, 4, 1'b0, 16'h3003, 0, 1'b0, 1'b0, 16'h3003, 2});
    drive_cyc = cyc;
    wait_done(300);
    req = '0;
    step();

    // Reset 20 cycles into WAIT: nothing completes and the pointer restarts.
    push('{4'b0010, 0, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 16'h0000, 1});
    req = 4'b0010;
    drive_cyc = cyc;
    for (int k = 0; k < 20 && !front_started; k++) step();
    chk("reset_seq_started", 32'(front_started), 32'd1);
    repeat (20) step();
    rst = 1'b1;
    req = '0;
    sb.delete();
    front_started = 1'b0;
    step();
    chk_quiet("mid_reset");
    rst = 1'b0;
    push('{4'b1001, 5, 1'b0, 16'h4444, 0, 1'b0, 1'b0, 16'h4444, 1});
    req = 4'b1001;
    drive_cyc = cyc;
    wait_done(300);
    req = '0;
    repeat (3) step();

    chk("abort_total", 32'(abort_cnt), 32'd1);
    chk("start_total", 32'(start_cnt), 32'(n_push));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_cfg_arbiter.md
# i2c_cfg_arbiter

Round-robin arbiter and transaction sequencer that shares one 16-bit-data I2C timing engine among up to N sensor-configuration requesters, e.g. one per MT9V034 in a multi-sensor build. Each requester posts a single register transaction; the block grants one at a time, launches the engine, and watches it with a timeout watchdog. It returns read data and status to the granted requester, and supports a lock for atomic multi-register sequences.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYC, 200_000: engine cycles allowed per transaction before abort, at most 2^24-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- req_lock  in  N_REQ  per-requester lock; keeps the grant after this transaction.
- req_cmd  in  32*N_REQ  per-requester command {slave_addr[7:0], reg_addr[7:0], wdata[15:0]}; slave_addr bit0=1 means read. Requester i occupies bits [32i+31:32i].
- gnt  out  N_REQ  one-hot grant.
- rsp_done  out  N_REQ  one-cycle completion pulse to the granted requester.
- rsp_err  out  1  NACK or timeout on the completed transaction; valid with rsp_done.
- rsp_timeout  out  1  timeout cause; valid with rsp_done.
- rsp_rdata  out  16  read data; valid with rsp_done; holds its value until the next completion.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_cmd  out  32  registered command; stable from eng_start until the next arbitration.
- eng_abort  out  1  one-cycle abort pulse on timeout.
- eng_done  in  1  engine completion pulse.
- eng_nack  in  1  engine NACK flag; sampled with eng_done.
- eng_rdata  in  16  engine read data; sampled with eng_done.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if req is nonzero, select the first asserted bit searching upward from ptr+1, wrapping modulo N_REQ.
  - Latch the index into sel, req_cmd[sel] into eng_cmd, set gnt[sel], and go to ISSUE.
  - If the lock is held, select owner only. While the lock is held, requests from other requesters are ignored.
- ISSUE: eng_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT, in priority order:
  - eng_done=1: capture eng_rdata; rsp_err=eng_nack; rsp_timeout=0; go to RESP.
  - Otherwise, watchdog == TIMEOUT_CYC-1: eng_abort=1 for one cycle; rsp_err=1; rsp_timeout=1; rsp_rdata unchanged; go to RESP.
  - Otherwise increment the watchdog.
- RESP: rsp_done[sel]=1 for one cycle; ptr <= sel.
  - If req_lock[sel]=1, record lock owner=sel; otherwise clear the lock.
  - Go to IDLE. gnt drops on entry to IDLE.
- The requester drops req, or presents its next cmd, in the cycle it sees rsp_done. The arbiter samples req again in IDLE one cycle later.
- A requester that drops req while granted does not cancel its transaction; it runs to completion.
- A locked owner that deasserts both req and req_lock in IDLE releases the lock immediately.
- eng_done is ignored outside WAIT. A done arriving in the same cycle the watchdog expires counts as done, with no abort.
- Reset values:
  - state=IDLE; ptr=N_REQ-1, so requester 0 wins first.
  - Lock cleared.
  - gnt, rsp_done, eng_start, eng_abort, rsp_err, rsp_timeout, busy all 0.
  - eng_cmd=0, rsp_rdata=0.
- Reset mid-transaction: return to IDLE with no rsp_done and no eng_abort. The engine is reset by the same rst.

## Timing
- req sampled high in IDLE at cycle t: gnt and eng_cmd valid at t+1, eng_start high at t+1.
- eng_done high at cycle d: rsp_done and rsp_data valid at d+1, IDLE at d+2, earliest next eng_start at d+3.
- Minimum transaction overhead is 3 cycles plus engine time.
- Timeout: eng_abort asserts TIMEOUT_CYC cycles after the eng_start cycle; rsp_done follows one cycle later.
- Fairness: with all requests held continuously, each requester is served once per N_REQ transactions when no lock is in use.

## Test plan
- Single request: req=4'b0010 with cmd 0x90_0D_0300; engine done after 50 cycles. Expect:
  - gnt=4'b0010 one cycle after req, with eng_start in the same cycle.
  - rsp_done[1] 51 cycles after eng_start, rsp_err=0.
- Contention: req=4'b1111 held, each engine transaction 10 cycles. Expect grant order 0,1,2,3,0 and exactly one eng_start per transaction.
- Read and NACK:
  - Read cmd 0x91_00_0000 with eng_rdata=0x1324 returns rsp_rdata=0x1324, rsp_err=0.
  - Next transaction with eng_nack=1 gives rsp_err=1, rsp_timeout=0, and rsp_rdata still 0x1324.
- Timeout: TIMEOUT_CYC=100, engine never done. Expect eng_abort exactly 100 cycles after eng_start, then rsp_done with rsp_err=1 and rsp_timeout=1. Arbitration resumes with the next requester.
- Lock: requester 2 asserts lock for 3 transactions while req[0] is held. Expect all three go to requester 2; requester 0 is granted right after the lock drops.
- Reset in WAIT: assert rst for 1 cycle 20 cycles after eng_start. Expect no rsp_done, all outputs 0, and ptr reset so that a new req=4'b1001 grants requester 0.
